// File: rtl/dual_port_ram_pkg.sv
// dual_port_ram_pkg: default geometry and word/address types for the dual-port RAM
package dual_port_ram_pkg;
   localparam int ADDR_SIZE  = 6;
   localparam int DATA_BITS  = 8;
   localparam int NO_OF_ADDR = 2 ** ADDR_SIZE;
   typedef logic [ADDR_SIZE-1:0] addr_t;
   typedef logic [DATA_BITS-1:0] word_t;
endpackage

// File: rtl/dual_port_ram_if.sv
// dual_port_ram_if: one RAM port (address, write enable, bidirectional data bus, read data)
interface dual_port_ram_if import dual_port_ram_pkg::*; #(
   parameter int AW = ADDR_SIZE,
   parameter int DW = DATA_BITS
);
   logic [AW-1:0] i_addr;
   logic          i_we;
   wire  [DW-1:0] io_dbus;
   logic [DW-1:0] o_dout;
   modport master (output i_addr, output i_we, inout io_dbus, input o_dout);
   modport slave  (input i_addr, input i_we, inout io_dbus, output o_dout);
endinterface

// File: rtl/dpram_port.sv
// dpram_port: per-port write decode, registered read data, bus readback when DBUS_READBACK_EN is defined
module dpram_port #(
   parameter int DW = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   dual_port_ram_if.slave p,
   input  logic [DW-1:0]  i_rdata,
   output logic           o_wr,
   output logic [DW-1:0]  o_wdata
);
   logic [DW-1:0] r_dout;
   logic          w_we;
   assign w_we     = p.i_we === 1'b1;
   assign o_wr     = rst_n && w_we;
   assign o_wdata  = p.io_dbus;
   assign p.o_dout = r_dout;
   // read register: cleared in reset, holds on writes, otherwise captures the pre-edge word
   always_ff @(posedge clk)
      if (!rst_n) r_dout <= '0;
      else if (!w_we) r_dout <= i_rdata;
`ifdef DBUS_READBACK_EN
   assign p.io_dbus = (rst_n && !w_we) ? r_dout : 'z;
`endif
endmodule

// File: rtl/dual_port_ram.sv
// dual_port_ram: true dual-port read-first RAM, port A wins write collisions; bus readback via DBUS_READBACK_EN
module dual_port_ram #(
   parameter int ADDR_SIZE  = dual_port_ram_pkg::ADDR_SIZE,
   parameter int DATA_BITS  = dual_port_ram_pkg::DATA_BITS,
   parameter int NO_OF_ADDR = dual_port_ram_pkg::NO_OF_ADDR
) (
   input  logic           clk,
   input  logic           rst_n,
   dual_port_ram_if.slave port_a,
   dual_port_ram_if.slave port_b
);
   logic [DATA_BITS-1:0] r_mem [NO_OF_ADDR];
   logic                 w_wr_a, w_wr_b;
   logic [DATA_BITS-1:0] w_wd_a, w_wd_b;
   dpram_port #(.DW(DATA_BITS)) u_port_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .p       (port_a),
      .i_rdata (r_mem[port_a.i_addr]),
      .o_wr    (w_wr_a),
      .o_wdata (w_wd_a)
   );
   dpram_port #(.DW(DATA_BITS)) u_port_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .p       (port_b),
      .i_rdata (r_mem[port_b.i_addr]),
      .o_wr    (w_wr_b),
      .o_wdata (w_wd_b)
   );
   // storage: B written first so a same-address A write overrides it
   always_ff @(posedge clk) begin
      if (w_wr_b) r_mem[port_b.i_addr] <= w_wd_b;
      if (w_wr_a) r_mem[port_a.i_addr] <= w_wd_a;
   end
endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: directed checks of writes, reads, collisions, reset and optional bus readback
module tb_dual_port_ram;
   import dual_port_ram_pkg::*;
   logic  clk = 1'b0;
   logic  rst_n;
   word_t r_da, r_db;
   int    total = 0;
   int    bad = 0;
   dual_port_ram_if ia ();
   dual_port_ram_if ib ();
   assign ia.io_dbus = r_da;
   assign ib.io_dbus = r_db;
   dual_port_ram u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .port_a (ia),
      .port_b (ib)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input word_t got, input word_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic drv(input addr_t aa, input logic wa, input word_t da,
                      input addr_t ab, input logic wb, input word_t db);
      ia.i_addr = aa; ia.i_we = wa; r_da = da;
      ib.i_addr = ab; ib.i_we = wb; r_db = db;
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst_n = 1'b0;
      drv(6'h00, 1'b0, 8'h00, 6'h00, 1'b0, 8'h00);
      cyc(); cyc();
      chk("rst_dout_a", ia.o_dout, 8'h00);
      chk("rst_dout_b", ib.o_dout, 8'h00);
      rst_n = 1'b1;
      drv(6'h01, 1'b1, 8'h33, 6'h02, 1'b1, 8'h44); cyc();
      chk("wr_hold_a", ia.o_dout, 8'h00);
      drv(6'h02, 1'b0, 8'h00, 6'h01, 1'b0, 8'h00); cyc();
      chk("rd1_b", ib.o_dout, 8'h33);
      chk("rd2_a", ia.o_dout, 8'h44);
      drv(6'h03, 1'b1, 8'h55, 6'h01, 1'b0, 8'h00); cyc();
      chk("ovl_b", ib.o_dout, 8'h33);
      chk("ovl_hold_a", ia.o_dout, 8'h44);
      drv(6'h02, 1'b0, 8'h00, 6'h03, 1'b0, 8'h00); cyc();
      chk("ovl_rd_a", ia.o_dout, 8'h44);
      chk("ovl_rd_b", ib.o_dout, 8'h55);
      drv(6'h02, 1'b0, 8'h00, 6'h02, 1'b1, 8'h77); cyc();
      chk("rdfirst_a", ia.o_dout, 8'h44);
      chk("rdfirst_hold_b", ib.o_dout, 8'h55);
      drv(6'h02, 1'b0, 8'h00, 6'h02, 1'b0, 8'h00); cyc();
      chk("reread_a", ia.o_dout, 8'h77);
      chk("same_rd_b", ib.o_dout, 8'h77);
      drv(6'h10, 1'b1, 8'hAA, 6'h10, 1'b1, 8'hBB); cyc();
      drv(6'h10, 1'b0, 8'h00, 6'h10, 1'b0, 8'h00); cyc();
      chk("ww_a", ia.o_dout, 8'hAA);
      chk("ww_b", ib.o_dout, 8'hAA);
      drv(6'h05, 1'b1, 8'h11, 6'h00, 1'b0, 8'h00); cyc();
      rst_n = 1'b0;
      drv(6'h05, 1'b1, 8'hCC, 6'h05, 1'b1, 8'hCC); cyc(); cyc();
      chk("rst2_dout_a", ia.o_dout, 8'h00);
      chk("rst2_dout_b", ib.o_dout, 8'h00);
      rst_n = 1'b1;
      drv(6'h05, 1'b0, 8'h00, 6'h10, 1'b0, 8'h00); cyc();
      chk("rst_nowr_a", ia.o_dout, 8'h11);
      chk("post_rst_b", ib.o_dout, 8'hAA);
      drv(6'h3F, 1'b1, 8'h5A, 6'h00, 1'b0, 8'h00); cyc();
      drv(6'h3F, 1'b0, 8'h00, 6'h3F, 1'b0, 8'h00);
`ifdef DBUS_READBACK_EN
      r_da = 'z; r_db = 'z;
`endif
      cyc();
      chk("top_a", ia.o_dout, 8'h5A);
      chk("top_b", ib.o_dout, 8'h5A);
`ifdef DBUS_READBACK_EN
      chk("rb_dbus_a", ia.io_dbus, 8'h5A);
      chk("rb_dbus_b", ib.io_dbus, 8'h5A);
      drv(6'h3F, 1'b1, 8'hC3, 6'h00, 1'b0, 8'h00);
      r_db = 'z;
      #1;
      chk("rel_dbus_a", ia.io_dbus, 8'hC3);
      cyc();
      drv(6'h3F, 1'b0, 8'h00, 6'h00, 1'b0, 8'h00);
      r_da = 'z; r_db = 'z;
      cyc();
      chk("rel_wr_a", ia.o_dout, 8'hC3);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
